// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding and buffer depth for the capture controller
package capture_pkg;
    typedef enum logic [2:0] {IDLE, FILL, WAIT_TRIG, POST, DONE} cap_state_t;
    function automatic int cap_depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/trig_detect.sv
// trig_detect: edge/level trigger compare against the previous accepted sample
module trig_detect #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_falling,
    input  logic                  force_trig,
    output logic                  hit
);
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;
    logic                  above_now;
    logic                  above_prev;
    always_comb begin
        above_now  = sample_in >= trig_level;
        above_prev = prev >= trig_level;
        hit        = en && (force_trig || (prev_valid &&
                     (trig_falling ? (above_prev && !above_now) : (!above_prev && above_now))));
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (en) begin
            prev       <= sample_in;
            prev_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: circular-buffer sample capture with pre/post trigger windows
module capture_ctrl import capture_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic                  arm,
    input  logic                  force_trig,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_falling,
    input  logic [ADDR_WIDTH-1:0] post_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    output logic                  ram_cs,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr
);
    localparam int DEPTH = cap_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(DEPTH - 1);
    cap_state_t            state;
    logic [ADDR_WIDTH-1:0] wr_ptr, fill_cnt, post_cnt, post_len_q, trig_pend, pre_min;
    logic                  act, take, hit, last;
    always_comb begin
        act     = state inside {FILL, WAIT_TRIG, POST};
        take    = act && sample_valid && !arm;
        pre_min = TOP - post_len_q;
        last    = (state == WAIT_TRIG && hit && post_len_q == '0) ||
                  (state == POST && post_cnt + 1'b1 == post_len_q);
    end
    trig_detect #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
        .clk(clk), .rst(rst), .clr(arm), .en(take), .sample_in(sample_in),
        .trig_level(trig_level), .trig_falling(trig_falling), .force_trig(force_trig), .hit(hit)
    );
    // trig_addr/start_addr are published only on DONE so readout never sees a half-finished capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            post_len_q <= '0;
            trig_pend  <= '0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_we     <= 1'b0;
            ram_cs     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            ram_we <= 1'b0;
            ram_cs <= 1'b0;
            if (arm) begin
                state      <= (post_len == TOP) ? WAIT_TRIG : FILL;
                post_len_q <= post_len;
                wr_ptr     <= '0;
                fill_cnt   <= '0;
                post_cnt   <= '0;
                busy       <= 1'b1;
                done       <= 1'b0;
            end else if (take) begin
                ram_we   <= 1'b1;
                ram_cs   <= 1'b1;
                ram_addr <= wr_ptr;
                ram_data <= sample_in;
                wr_ptr   <= wr_ptr + 1'b1;
                fill_cnt <= (fill_cnt == TOP) ? fill_cnt : fill_cnt + 1'b1;
                if (state == FILL && fill_cnt + 1'b1 == pre_min)
                    state <= WAIT_TRIG;
                if (state == WAIT_TRIG && hit) begin
                    trig_pend <= wr_ptr;
                    state     <= POST;
                end
                if (state == POST)
                    post_cnt <= post_cnt + 1'b1;
                if (last) begin
                    state      <= DONE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    trig_addr  <= (state == WAIT_TRIG) ? wr_ptr : trig_pend;
                    start_addr <= wr_ptr + 1'b1;
                end
            end
        end
    end
endmodule
